// File: rtl/dmem_sram_like_port.sv
// M-stage data-memory responder: turns one core access into a single sram-like transaction
// and holds the read result until the pipeline advances.
module dmem_sram_like_port #(
    parameter int unsigned ADDR_W   = 32,
    parameter bit          KSEG_MAP = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic              i_mem_en,
    input  logic [3:0]        i_mem_wen,
    input  logic [1:0]        i_mem_rsize,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [31:0]       i_mem_wdata,
    input  logic              i_mem_flush,
    input  logic              i_longest_stall,
    output logic [31:0]       o_mem_rdata,
    output logic              o_data_stall,
    output logic              o_data_req,
    output logic              o_data_wr,
    output logic [1:0]        o_data_size,
    output logic [ADDR_W-1:0] o_data_addr,
    output logic [31:0]       o_data_wdata,
    input  logic              i_data_addr_ok,
    input  logic              i_data_data_ok,
    input  logic [31:0]       i_data_rdata
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StHold} state_e;

    state_e              r_state;
    logic                r_drop;
    logic                r_wr;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;

    logic [ADDR_W-1:0]   w_phys_addr;
    logic [1:0]          w_size;
    logic                w_drop_now;
    logic                w_done;

    always_comb begin
        w_phys_addr = i_mem_addr;
        if (KSEG_MAP && (i_mem_addr[ADDR_W-1 -: 2] == 2'b10)) begin
            w_phys_addr = {3'b000, i_mem_addr[ADDR_W-4:0]};
        end
    end

    always_comb begin
        if (i_mem_wen == 4'b0000) begin
            w_size = i_mem_rsize;
        end else begin
            case (i_mem_wen)
                4'b1111:          w_size = 2'd2;
                4'b0011, 4'b1100: w_size = 2'd1;
                default:          w_size = 2'd0;
            endcase
        end
    end

    // A flush arriving in the completion cycle already counts as a drop.
    assign w_drop_now = r_drop | i_mem_flush;
    assign w_done     = ((r_state == StAddr) & i_data_addr_ok & i_data_data_ok)
                      | ((r_state == StData) & i_data_data_ok);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= StIdle;
            r_drop  <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_drop <= 1'b0;
                    if (i_mem_en && !i_mem_flush) begin
                        r_state <= StAddr;
                        r_wr    <= |i_mem_wen;
                        r_size  <= w_size;
                        r_addr  <= w_phys_addr;
                        r_wdata <= i_mem_wdata;
                    end
                end
                StAddr, StData: begin
                    if (w_done) begin
                        r_drop <= 1'b0;
                        if (w_drop_now) begin
                            r_state <= StIdle;
                        end else begin
                            r_state <= StHold;
                            if (!r_wr) begin
                                r_rdata <= i_data_rdata;
                            end
                        end
                    end else begin
                        r_drop <= w_drop_now;
                        if ((r_state == StAddr) && i_data_addr_ok) begin
                            r_state <= StData;
                        end
                    end
                end
                StHold: begin
                    if (!i_longest_stall || i_mem_flush) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_data_req   = (r_state == StAddr);
    assign o_data_wr    = r_wr;
    assign o_data_size  = r_size;
    assign o_data_addr  = r_addr;
    assign o_data_wdata = r_wdata;
    assign o_mem_rdata  = r_rdata;
    assign o_data_stall = i_resetn & i_mem_en & ~i_mem_flush & (r_state != StHold) & ~r_drop;

endmodule

// File: tb/tb_dmem_sram_like_port.sv
// Bench for dmem_sram_like_port: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model of the port.
module tb_dmem_sram_like_port;

    logic        clk;
    logic        s_resetn, s_en, s_flush, s_lstall, s_aok, s_dok;
    logic [3:0]  s_wen;
    logic [1:0]  s_rsize;
    logic [31:0] s_addr, s_wdata, s_rdata;

    logic [31:0] mem_rdata, data_addr, data_wdata;
    logic        data_stall, data_req, data_wr;
    logic [1:0]  data_size;

    int n_checks = 0;
    int n_fail   = 0;
    int n_reqs   = 0;
    logic prev_req = 1'b0;

    // Transaction-level model
    bit          m_have, m_acc, m_hold, m_drop;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;

    dmem_sram_like_port #(.ADDR_W(32), .KSEG_MAP(1'b1)) dut (
        .i_clk          (clk),
        .i_resetn       (s_resetn),
        .i_mem_en       (s_en),
        .i_mem_wen      (s_wen),
        .i_mem_rsize    (s_rsize),
        .i_mem_addr     (s_addr),
        .i_mem_wdata    (s_wdata),
        .i_mem_flush    (s_flush),
        .i_longest_stall(s_lstall),
        .o_mem_rdata    (mem_rdata),
        .o_data_stall   (data_stall),
        .o_data_req     (data_req),
        .o_data_wr      (data_wr),
        .o_data_size    (data_size),
        .o_data_addr    (data_addr),
        .o_data_wdata   (data_wdata),
        .i_data_addr_ok (s_aok),
        .i_data_data_ok (s_dok),
        .i_data_rdata   (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] phys(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a & 32'h1FFF_FFFF;
        return a;
    endfunction

    function automatic logic [1:0] size_of(input logic [3:0] wen, input logic [1:0] rsize);
        if (wen == 4'b0000) return rsize;
        case ($countones(wen))
            4:       return 2'd2;
            2:       return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_have = 0; m_acc = 0; m_hold = 0; m_drop = 0;
        m_wr = 0; m_size = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
    endtask

    task automatic model_step();
        bit dn;
        dn = m_drop | s_flush;
        if (m_hold) begin
            if (!s_lstall || s_flush) m_hold = 0;
        end else if (m_have) begin
            if ((!m_acc && s_aok && s_dok) || (m_acc && s_dok)) begin
                m_have = 0; m_acc = 0; m_drop = 0;
                if (!dn) begin
                    m_hold = 1;
                    if (!m_wr) m_rdata = s_rdata;
                end
            end else begin
                m_drop = dn;
                if (s_aok) m_acc = 1;
            end
        end else if (s_en && !s_flush) begin
            m_have  = 1; m_acc = 0; m_drop = 0;
            m_wr    = (s_wen != 4'b0000);
            m_size  = size_of(s_wen, s_rsize);
            m_addr  = phys(s_addr);
            m_wdata = s_wdata;
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model across the edge.
    task automatic tick();
        #0;
        if (!s_resetn) model_reset();
        @(negedge clk);
        chk("req",   {31'b0, data_req},   {31'b0, m_have & ~m_acc});
        chk("wr",    {31'b0, data_wr},    {31'b0, m_wr});
        chk("size",  {30'b0, data_size},  {30'b0, m_size});
        chk("addr",  data_addr,           m_addr);
        chk("wdata", data_wdata,          m_wdata);
        chk("rdata", mem_rdata,           m_rdata);
        chk("stall", {31'b0, data_stall},
            {31'b0, s_resetn & s_en & ~s_flush & ~m_hold & ~m_drop});
        if (data_req && !prev_req) n_reqs++;
        prev_req = data_req;
        @(posedge clk);
        if (s_resetn) model_step();
        #1;
    endtask

    task automatic idle_inputs();
        s_en = 0; s_wen = 0; s_rsize = 0; s_addr = 0; s_wdata = 0;
        s_flush = 0; s_lstall = 0; s_aok = 0; s_dok = 0; s_rdata = 0;
    endtask

    task automatic start_read(input logic [31:0] a);
        s_en = 1; s_wen = 0; s_rsize = 2; s_addr = a; s_lstall = 1; s_flush = 0;
        s_aok = 0; s_dok = 0;
        tick();
    endtask

    initial begin
        int r0;
        logic [3:0] wen_tab [10];
        wen_tab = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
        model_reset();
        idle_inputs();
        s_resetn = 0;
        tick();
        tick();
        chk("reset_addr", data_addr, 32'h0);
        chk("reset_req", {31'b0, data_req}, 32'h0);
        s_resetn = 1;
        tick();

        // Word read through kseg0
        start_read(32'h8000_1000);
        chk("t1_req", {31'b0, data_req}, 32'h1);
        chk("t1_addr", data_addr, 32'h0000_1000);
        chk("t1_size", {30'b0, data_size}, 32'h2);
        chk("t1_wr", {31'b0, data_wr}, 32'h0);
        tick();
        s_aok = 1; tick();
        s_aok = 0; tick();
        s_dok = 1; s_rdata = 32'hDEAD_BEEF; tick();
        s_dok = 0;
        chk("t1_rdata", mem_rdata, 32'hDEAD_BEEF);
        chk("t1_stall", {31'b0, data_stall}, 32'h0);
        s_lstall = 0; tick();
        idle_inputs(); tick();

        // Byte store through kseg1, same-cycle handshake
        r0 = n_reqs;
        s_en = 1; s_wen = 4'b0100; s_addr = 32'hA000_0006; s_wdata = 32'h00AB_0000; s_lstall = 1;
        tick();
        chk("t2_size", {30'b0, data_size}, 32'h0);
        chk("t2_wr", {31'b0, data_wr}, 32'h1);
        chk("t2_addr", data_addr, 32'h0000_0006);
        s_aok = 1; s_dok = 1; tick();
        s_aok = 0; s_dok = 0;
        chk("t2_hold_req", {31'b0, data_req}, 32'h0);
        chk("t2_hold_stall", {31'b0, data_stall}, 32'h0);
        s_lstall = 0; tick();
        idle_inputs(); tick();
        chk("t2_one_req", n_reqs - r0, 1);

        // Long global stall while holding read data
        r0 = n_reqs;
        start_read(32'h0000_2000);
        s_aok = 1; s_dok = 1; s_rdata = 32'h1234_5678; tick();
        s_aok = 0; s_dok = 0; s_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_rdata", mem_rdata, 32'h1234_5678);
            chk("t3_req", {31'b0, data_req}, 32'h0);
        end
        s_lstall = 0; tick();
        idle_inputs(); tick();
        chk("t3_one_req", n_reqs - r0, 1);

        // Flush before addr_ok: handshake completes, data discarded
        start_read(32'h0000_3000);
        s_flush = 1; tick();
        chk("t4_req_held", {31'b0, data_req}, 32'h1);
        chk("t4_stall", {31'b0, data_stall}, 32'h0);
        s_aok = 1; tick();
        s_aok = 0; s_dok = 1; s_rdata = 32'h0000_0BAD; tick();
        s_dok = 0;
        chk("t4_rdata", mem_rdata, 32'h1234_5678);
        chk("t4_req", {31'b0, data_req}, 32'h0);
        idle_inputs(); tick();

        // Reset while waiting for data
        start_read(32'h0000_4000);
        s_aok = 1; tick();
        s_aok = 0; s_resetn = 0; tick();
        chk("t5_rdata", mem_rdata, 32'h0);
        chk("t5_addr", data_addr, 32'h0);
        chk("t5_req", {31'b0, data_req}, 32'h0);
        s_resetn = 1; idle_inputs(); tick(); tick();
        chk("t5_no_req", {31'b0, data_req}, 32'h0);

        // Back-to-back loads
        r0 = n_reqs;
        start_read(32'h0000_5000);
        s_aok = 1; s_dok = 1; s_rdata = 32'h0000_0001; tick();
        s_aok = 0; s_dok = 0; s_lstall = 0; tick();
        s_addr = 32'h8000_6004; s_lstall = 1; tick();
        chk("t6_addr2", data_addr, 32'h0000_6004);
        s_aok = 1; s_dok = 1; s_rdata = 32'h0000_0002; tick();
        s_aok = 0; s_dok = 0;
        chk("t6_rdata2", mem_rdata, 32'h0000_0002);
        s_lstall = 0; tick();
        idle_inputs(); tick();
        chk("t6_two_reqs", n_reqs - r0, 2);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            s_resetn = ($urandom_range(0, 199) != 0);
            s_aok = 0; s_dok = 0; s_rdata = $urandom;
            if (m_hold) begin
                s_lstall = $urandom_range(0, 1);
                s_flush  = ($urandom_range(0, 19) == 0);
                s_dok    = ($urandom_range(0, 9) == 0);
            end else if (m_have) begin
                s_lstall = 1;
                s_flush  = ($urandom_range(0, 11) == 0);
                s_aok    = m_acc ? 1'b0 : ($urandom_range(0, 1) == 1);
                s_dok    = (m_acc || s_aok) ? ($urandom_range(0, 4) < 2) : 1'b0;
            end else begin
                s_en     = ($urandom_range(0, 9) < 6);
                s_wen    = wen_tab[$urandom_range(0, 9)];
                s_rsize  = 2'($urandom_range(0, 2));
                s_addr   = {2'($urandom_range(0, 3)), 30'($urandom)};
                s_wdata  = $urandom;
                s_flush  = ($urandom_range(0, 9) == 0);
                s_lstall = 1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
